// File: rtl/bit_pattern_detector_pkg.sv
// -----------------------------------------------------------------------------
// bit_pattern_pkg
// Shared types and helpers for the serial bit-pattern detector.
//   state_e  : detector FSM state, 2-bit (IDLE=0, HUNT=1, LOCKED=2, ERR=3)
//   len_w    : width needed to hold a pattern length 0..max_len
//   len_mask : mask with the low 'len' bits set, used by the comparator
// -----------------------------------------------------------------------------
package bit_pattern_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_HUNT   = 2'd1,
        ST_LOCKED = 2'd2,
        ST_ERR    = 2'd3
    } state_e;

    // One extra bit so that max_len itself (and one past it) is representable.
    function automatic int len_w(input int max_len);
        return $clog2(max_len) + 1;
    endfunction

    // Low-len-bit compare mask; callers size it down to their pattern width.
    function automatic logic [31:0] len_mask(input logic [31:0] len);
        logic [31:0] mask;
        if (len >= 32'd32) begin
            mask = 32'hFFFF_FFFF;
        end else begin
            mask = (32'd1 << len) - 32'd1;
        end
        return mask;
    endfunction

endpackage

// File: rtl/bit_pattern_detector_if.sv
// -----------------------------------------------------------------------------
// bit_pattern_detector_if
// Control, configuration, serial stream and status bundle of the detector.
//   master : drives en/clr/cfg_*/din_valid/din, observes status
//   slave  : the detector; observes controls, drives match/lock/match_cnt/
//            cfg_err/state
// -----------------------------------------------------------------------------
interface bit_pattern_detector_if #(
    parameter int MAX_LEN = 8,
    parameter int CNT_W   = 8
);
    import bit_pattern_pkg::*;

    localparam int LEN_W = len_w(MAX_LEN);

    logic               en;
    logic               clr;
    logic [MAX_LEN-1:0] cfg_pattern;
    logic [LEN_W-1:0]   cfg_len;
    logic               cfg_overlap;
    logic               din_valid;
    logic               din;
    logic               match;
    logic               lock;
    logic [CNT_W-1:0]   match_cnt;
    logic               cfg_err;
    logic [1:0]         state;

    modport master (
        output en, clr, cfg_pattern, cfg_len, cfg_overlap, din_valid, din,
        input  match, lock, match_cnt, cfg_err, state
    );

    modport slave (
        input  en, clr, cfg_pattern, cfg_len, cfg_overlap, din_valid, din,
        output match, lock, match_cnt, cfg_err, state
    );

endinterface

// File: rtl/bit_pattern_detector_match_window.sv
// -----------------------------------------------------------------------------
// pattern_match_window
// History shift register, fill counter and masked comparator.
//   clk, rst_n  : clock, async active-low reset
//   clear_i     : drop all history and fill
//   shift_i     : accept din_i this cycle
//   din_i       : serial bit, enters at the LSB
//   pattern_i   : pattern, bit len_i-1 is the oldest bit
//   len_i       : active pattern length
//   overlap_i   : 0 = restart fill after a hit so bits are not reused
//   hit_o       : combinational; the bit being shifted in completes a match
// -----------------------------------------------------------------------------
module pattern_match_window
    import bit_pattern_pkg::*;
#(
    parameter int MAX_LEN = 8,
    parameter int LEN_W   = len_w(MAX_LEN)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               clear_i,
    input  logic               shift_i,
    input  logic               din_i,
    input  logic [MAX_LEN-1:0] pattern_i,
    input  logic [LEN_W-1:0]   len_i,
    input  logic               overlap_i,
    output logic               hit_o
);

    logic [MAX_LEN-1:0] hist_q, hist_d, hist_shift_s;
    logic [LEN_W-1:0]   fill_q, fill_d, fill_inc_s;
    logic [31:0]        mask_s;
    logic [31:0]        diff_s;
    logic               hit_s;

    // Compare on the value that would be shifted in this cycle.
    always_comb begin
        hist_shift_s = {hist_q[MAX_LEN-2:0], din_i};
        if (fill_q >= LEN_W'(MAX_LEN)) begin
            fill_inc_s = fill_q;
        end else begin
            fill_inc_s = fill_q + LEN_W'(1);
        end
        mask_s = len_mask(32'(len_i));
        diff_s = 32'(hist_shift_s ^ pattern_i) & mask_s;
        hit_s  = shift_i && (fill_inc_s >= len_i) && (diff_s == 32'd0);
        hit_o  = hit_s;
    end

    // Next history and fill; a non-overlap hit empties the fill count.
    always_comb begin
        hist_d = hist_q;
        fill_d = fill_q;
        if (clear_i) begin
            hist_d = '0;
            fill_d = '0;
        end else if (shift_i) begin
            hist_d = hist_shift_s;
            if (hit_s && !overlap_i) begin
                fill_d = '0;
            end else begin
                fill_d = fill_inc_s;
            end
        end else begin
            hist_d = hist_q;
            fill_d = fill_q;
        end
    end

    // History and fill registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hist_q <= '0;
            fill_q <= '0;
        end else begin
            hist_q <= hist_d;
            fill_q <= fill_d;
        end
    end

endmodule

// File: rtl/bit_pattern_detector.sv
// -----------------------------------------------------------------------------
// bit_pattern_detector
// Programmable serial bit-stream pattern detector with lock indication.
//   clk, rst_n      : clock, async active-low reset
//   bus (slave)     : en, clr, cfg_pattern, cfg_len, cfg_overlap, din_valid,
//                     din in; match, lock, match_cnt, cfg_err, state out
// Config is captured on the first enabled cycle in IDLE and held until en
// drops. All status outputs are registered.
// -----------------------------------------------------------------------------
module bit_pattern_detector
    import bit_pattern_pkg::*;
#(
    parameter int MAX_LEN     = 8,
    parameter int CNT_W       = 8,
    parameter int LOCK_THRESH = 1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    bit_pattern_detector_if.slave    bus
);

    localparam int               LEN_W    = len_w(MAX_LEN);
    localparam logic [CNT_W-1:0] THRESH_C = CNT_W'(LOCK_THRESH);
    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

    state_e             state_q, state_d;
    logic [MAX_LEN-1:0] pat_q, pat_d;
    logic [LEN_W-1:0]   len_q, len_d;
    logic               ovl_q, ovl_d;
    logic               match_q, match_d;
    logic               lock_q, lock_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               cfg_err_q, cfg_err_d;

    logic               active_s;
    logic               shift_s;
    logic               clear_s;
    logic               hit_s;
    logic               cfg_bad_s;

    // Window control: en=0 beats clr beats din_valid.
    always_comb begin
        active_s  = (state_q == ST_HUNT) || (state_q == ST_LOCKED);
        shift_s   = active_s && bus.en && !bus.clr && bus.din_valid;
        clear_s   = !active_s || !bus.en || bus.clr;
        cfg_bad_s = (bus.cfg_len == LEN_W'(0)) || (bus.cfg_len > LEN_W'(MAX_LEN));
    end

    pattern_match_window #(
        .MAX_LEN (MAX_LEN),
        .LEN_W   (LEN_W)
    ) u_window (
        .clk       (clk),
        .rst_n     (rst_n),
        .clear_i   (clear_s),
        .shift_i   (shift_s),
        .din_i     (bus.din),
        .pattern_i (pat_q),
        .len_i     (len_q),
        .overlap_i (ovl_q),
        .hit_o     (hit_s)
    );

    // Next-state, config shadow, counter and status outputs.
    always_comb begin
        state_d = state_q;
        pat_d   = pat_q;
        len_d   = len_q;
        ovl_d   = ovl_q;
        match_d = 1'b0;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE: begin
                cnt_d = '0;
                if (bus.en) begin
                    pat_d = bus.cfg_pattern;
                    len_d = bus.cfg_len;
                    ovl_d = bus.cfg_overlap;
                    if (cfg_bad_s) begin
                        state_d = ST_ERR;
                    end else begin
                        state_d = ST_HUNT;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_ERR: begin
                cnt_d = '0;
                if (!bus.en) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_ERR;
                end
            end
            ST_HUNT, ST_LOCKED: begin
                if (!bus.en) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end else if (bus.clr) begin
                    state_d = ST_HUNT;
                    cnt_d   = '0;
                end else if (hit_s) begin
                    match_d = 1'b1;
                    if (cnt_q == CNT_MAX) begin
                        cnt_d = cnt_q;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                    if (cnt_d >= THRESH_C) begin
                        state_d = ST_LOCKED;
                    end else begin
                        state_d = state_q;
                    end
                end else begin
                    state_d = state_q;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
        // Lock and error flags mirror the state being entered so they rise
        // on the same edge as the match that caused them.
        lock_d    = (state_d == ST_LOCKED);
        cfg_err_d = (state_d == ST_ERR);
    end

    // State, shadow config and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            pat_q     <= '0;
            len_q     <= '0;
            ovl_q     <= 1'b0;
            match_q   <= 1'b0;
            lock_q    <= 1'b0;
            cnt_q     <= '0;
            cfg_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            pat_q     <= pat_d;
            len_q     <= len_d;
            ovl_q     <= ovl_d;
            match_q   <= match_d;
            lock_q    <= lock_d;
            cnt_q     <= cnt_d;
            cfg_err_q <= cfg_err_d;
        end
    end

    assign bus.match     = match_q;
    assign bus.lock      = lock_q;
    assign bus.match_cnt = cnt_q;
    assign bus.cfg_err   = cfg_err_q;
    assign bus.state     = state_q;

endmodule

// File: tb/tb_bit_pattern_detector.sv
// -----------------------------------------------------------------------------
// tb_bit_pattern_detector
// Directed bench. dut_a: MAX_LEN=8, CNT_W=8, LOCK_THRESH=2.
//                 dut_b: MAX_LEN=8, CNT_W=3, LOCK_THRESH=1 (saturation).
// Inputs are driven and outputs sampled 1 time unit after each rising edge.
// -----------------------------------------------------------------------------
module tb_bit_pattern_detector;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_cmp = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;

    bit_pattern_detector_if #(.MAX_LEN(8), .CNT_W(8)) ifa ();
    bit_pattern_detector_if #(.MAX_LEN(8), .CNT_W(3)) ifb ();

    bit_pattern_detector #(.MAX_LEN(8), .CNT_W(8), .LOCK_THRESH(2)) dut_a (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (ifa.slave)
    );

    bit_pattern_detector #(.MAX_LEN(8), .CNT_W(3), .LOCK_THRESH(1)) dut_b (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (ifb.slave)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drop enable for one cycle, then enable dut_a with a new config.
    task automatic cfg_a(input logic [7:0] pat, input logic [3:0] len, input logic ovl);
        ifa.en = 1'b0;
        ifa.clr = 1'b0;
        ifa.din_valid = 1'b0;
        tick();
        ifa.cfg_pattern = pat;
        ifa.cfg_len = len;
        ifa.cfg_overlap = ovl;
        ifa.en = 1'b1;
        tick();
    endtask

    task automatic bit_a(input logic b);
        ifa.din_valid = 1'b1;
        ifa.din = b;
        tick();
        ifa.din_valid = 1'b0;
    endtask

    task automatic test_reset();
        ifa.en = 1'b0; ifa.clr = 1'b0; ifa.cfg_pattern = 8'd0; ifa.cfg_len = 4'd0;
        ifa.cfg_overlap = 1'b0; ifa.din_valid = 1'b0; ifa.din = 1'b0;
        ifb.en = 1'b0; ifb.clr = 1'b0; ifb.cfg_pattern = 8'd0; ifb.cfg_len = 4'd0;
        ifb.cfg_overlap = 1'b0; ifb.din_valid = 1'b0; ifb.din = 1'b0;
        tick();
        tick();
        n_cmp++;
        if ({ifa.match, ifa.lock, ifa.match_cnt, ifa.cfg_err, ifa.state} !== 13'd0) begin
            $display("FAIL reset_a: got m=%b l=%b c=%0d e=%b s=%0d want all 0",
                     ifa.match, ifa.lock, ifa.match_cnt, ifa.cfg_err, ifa.state);
            n_fail++;
        end
        n_cmp++;
        if ({ifb.match, ifb.lock, ifb.match_cnt, ifb.cfg_err, ifb.state} !== 8'd0) begin
            $display("FAIL reset_b: got m=%b l=%b c=%0d e=%b s=%0d want all 0",
                     ifb.match, ifb.lock, ifb.match_cnt, ifb.cfg_err, ifb.state);
            n_fail++;
        end
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_overlap();
        logic s_v [7] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
        logic m_v [7] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
        cfg_a(8'b0000_1001, 4'd4, 1'b1);
        n_cmp++;
        if (ifa.state !== 2'd1) begin
            $display("FAIL ovl_hunt: state got %0d want 1", ifa.state);
            n_fail++;
        end
        for (int i = 0; i < 7; i++) begin
            bit_a(s_v[i]);
            n_cmp++;
            if (ifa.match !== m_v[i] || ifa.lock !== (i == 6)) begin
                $display("FAIL ovl_bit%0d: match/lock got %b/%b want %b/%b",
                         i + 1, ifa.match, ifa.lock, m_v[i], (i == 6));
                n_fail++;
            end
        end
        n_cmp++;
        if (ifa.match_cnt !== 8'd2 || ifa.state !== 2'd2) begin
            $display("FAIL ovl_end: cnt/state got %0d/%0d want 2/2", ifa.match_cnt, ifa.state);
            n_fail++;
        end
    endtask

    task automatic test_non_overlap();
        logic s_v [10] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
        logic m_v [10] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        cfg_a(8'b0000_1001, 4'd4, 1'b0);
        for (int i = 0; i < 10; i++) begin
            bit_a(s_v[i]);
            n_cmp++;
            if (ifa.match !== m_v[i]) begin
                $display("FAIL novl_bit%0d: match got %b want %b", i + 1, ifa.match, m_v[i]);
                n_fail++;
            end
            if (i == 6) begin
                n_cmp++;
                if (ifa.match_cnt !== 8'd1 || ifa.lock !== 1'b0) begin
                    $display("FAIL novl_mid: cnt/lock got %0d/%b want 1/0", ifa.match_cnt, ifa.lock);
                    n_fail++;
                end
            end
        end
        n_cmp++;
        if (ifa.match_cnt !== 8'd2 || ifa.lock !== 1'b1) begin
            $display("FAIL novl_end: cnt/lock got %0d/%b want 2/1", ifa.match_cnt, ifa.lock);
            n_fail++;
        end
    endtask

    task automatic test_valid_gaps();
        logic s_v [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
        int   seen = 0;
        cfg_a(8'b0000_1001, 4'd4, 1'b1);
        for (int i = 0; i < 4; i++) begin
            bit_a(s_v[i]);
            n_cmp++;
            if (ifa.match !== (i == 3)) begin
                $display("FAIL gap_bit%0d: match got %b want %b", i + 1, ifa.match, (i == 3));
                n_fail++;
            end
            if (ifa.match === 1'b1) seen++;
            for (int g = 0; g < 2; g++) begin
                ifa.din = ~ifa.din;
                tick();
                if (ifa.match === 1'b1) seen++;
            end
        end
        n_cmp++;
        if (seen != 1 || ifa.match_cnt !== 8'd1) begin
            $display("FAIL gap_total: pulses/cnt got %0d/%0d want 1/1", seen, ifa.match_cnt);
            n_fail++;
        end
    endtask

    task automatic test_clr_priority();
        logic s_v [7] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
        logic t_v [3] = '{1'b0, 1'b0, 1'b1};
        cfg_a(8'b0000_1001, 4'd4, 1'b1);
        for (int i = 0; i < 7; i++) bit_a(s_v[i]);
        n_cmp++;
        if (ifa.match_cnt !== 8'd1 || ifa.match !== 1'b0) begin
            $display("FAIL clr_pre: cnt/match got %0d/%b want 1/0", ifa.match_cnt, ifa.match);
            n_fail++;
        end
        ifa.clr = 1'b1;
        bit_a(1'b1);
        ifa.clr = 1'b0;
        n_cmp++;
        if (ifa.match !== 1'b0 || ifa.match_cnt !== 8'd0 || ifa.lock !== 1'b0 || ifa.state !== 2'd1) begin
            $display("FAIL clr_edge: m/c/l/s got %b/%0d/%b/%0d want 0/0/0/1",
                     ifa.match, ifa.match_cnt, ifa.lock, ifa.state);
            n_fail++;
        end
        // History was emptied: a lone 1 cannot complete the pattern.
        bit_a(1'b1);
        n_cmp++;
        if (ifa.match !== 1'b0) begin
            $display("FAIL clr_hist: match got %b want 0", ifa.match);
            n_fail++;
        end
        for (int i = 0; i < 3; i++) bit_a(t_v[i]);
        n_cmp++;
        if (ifa.match !== 1'b1 || ifa.match_cnt !== 8'd1) begin
            $display("FAIL clr_after: match/cnt got %b/%0d want 1/1", ifa.match, ifa.match_cnt);
            n_fail++;
        end
    endtask

    task automatic test_config_err();
        logic [3:0] bad_v [2] = '{4'd0, 4'd9};
        logic       s_v [8] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
        for (int k = 0; k < 2; k++) begin
            cfg_a(8'b0000_1001, bad_v[k], 1'b1);
            n_cmp++;
            if (ifa.state !== 2'd3 || ifa.cfg_err !== 1'b1) begin
                $display("FAIL cfg_err_len%0d: state/err got %0d/%b want 3/1", bad_v[k], ifa.state, ifa.cfg_err);
                n_fail++;
            end
            for (int i = 0; i < 8; i++) begin
                bit_a(s_v[i]);
                n_cmp++;
                if (ifa.match !== 1'b0 || ifa.state !== 2'd3) begin
                    $display("FAIL cfg_nomatch_len%0d_bit%0d: match/state got %b/%0d want 0/3",
                             bad_v[k], i + 1, ifa.match, ifa.state);
                    n_fail++;
                end
            end
            ifa.clr = 1'b1;
            tick();
            ifa.clr = 1'b0;
            n_cmp++;
            if (ifa.state !== 2'd3) begin
                $display("FAIL cfg_clr_len%0d: state got %0d want 3", bad_v[k], ifa.state);
                n_fail++;
            end
            ifa.en = 1'b0;
            tick();
            n_cmp++;
            if (ifa.state !== 2'd0 || ifa.cfg_err !== 1'b0 || ifa.match_cnt !== 8'd0) begin
                $display("FAIL cfg_exit_len%0d: state/err/cnt got %0d/%b/%0d want 0/0/0",
                         bad_v[k], ifa.state, ifa.cfg_err, ifa.match_cnt);
                n_fail++;
            end
        end
    endtask

    task automatic test_saturation();
        logic [2:0] exp_cnt;
        ifb.en = 1'b0;
        tick();
        ifb.cfg_pattern = 8'b0000_0001;
        ifb.cfg_len = 4'd1;
        ifb.cfg_overlap = 1'b1;
        ifb.en = 1'b1;
        tick();
        for (int i = 0; i < 12; i++) begin
            ifb.din_valid = 1'b1;
            ifb.din = 1'b1;
            tick();
            exp_cnt = (i >= 6) ? 3'd7 : 3'(i + 1);
            n_cmp++;
            if (ifb.match !== 1'b1 || ifb.match_cnt !== exp_cnt || ifb.lock !== 1'b1) begin
                $display("FAIL sat_bit%0d: match/cnt/lock got %b/%0d/%b want 1/%0d/1",
                         i + 1, ifb.match, ifb.match_cnt, ifb.lock, exp_cnt);
                n_fail++;
            end
        end
        ifb.din = 1'b0;
        tick();
        n_cmp++;
        if (ifb.match !== 1'b0 || ifb.match_cnt !== 3'd7) begin
            $display("FAIL sat_zero: match/cnt got %b/%0d want 0/7", ifb.match, ifb.match_cnt);
            n_fail++;
        end
        ifb.din_valid = 1'b0;
        ifb.en = 1'b0;
        tick();
    endtask

    task automatic test_async_reset();
        cfg_a(8'b0000_0001, 4'd1, 1'b1);
        for (int i = 0; i < 5; i++) bit_a(1'b1);
        n_cmp++;
        if (ifa.match_cnt !== 8'd5 || ifa.lock !== 1'b1 || ifa.state !== 2'd2) begin
            $display("FAIL arst_pre: cnt/lock/state got %0d/%b/%0d want 5/1/2",
                     ifa.match_cnt, ifa.lock, ifa.state);
            n_fail++;
        end
        ifa.din_valid = 1'b1;
        ifa.din = 1'b1;
        #2;
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({ifa.match, ifa.lock, ifa.match_cnt, ifa.cfg_err, ifa.state} !== 13'd0) begin
            $display("FAIL arst_now: got m=%b l=%b c=%0d e=%b s=%0d want all 0",
                     ifa.match, ifa.lock, ifa.match_cnt, ifa.cfg_err, ifa.state);
            n_fail++;
        end
        ifa.din_valid = 1'b0;
        ifa.en = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    initial begin
        test_reset();
        test_overlap();
        test_non_overlap();
        test_valid_gaps();
        test_clr_priority();
        test_config_err();
        test_saturation();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
